// File: rtl/nibble_sram_bridge.sv
// Nibble-serial word memory: address strobe, LS-nibble-first data phases, all-or-nothing commits.
// Define NIBSRAM_BURST_EN to auto-increment the word address each time nib_sel wraps.
module nibble_sram_bridge #(
    parameter  int ADDR_W = 7,
    parameter  int NIB_W  = 4,
    parameter  int NIBS   = 2,
    localparam int SEL_W  = $clog2(NIBS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_strobe,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              wr_n,
    input  logic [NIB_W-1:0]  wdata_nib,
    output logic [NIB_W-1:0]  rdata_nib,
    output logic [SEL_W-1:0]  nib_sel
);

    localparam int               DEPTH    = 2 ** ADDR_W;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NIBS - 1);

    typedef logic [NIBS-1:0][NIB_W-1:0] word_t;

    word_t             mem [DEPTH];

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              wr_ok_q, wr_ok_d;
    logic [NIB_W-1:0]  rdata_q, rdata_d;
    logic [NIB_W-1:0]  shadow_q [NIBS-1];

    logic              data_phase;
    logic              last_nib;
    logic              commit;
    word_t             commit_word;
    word_t             load_word;

    assign data_phase = ~addr_strobe;
    assign last_nib   = (sel_q == LAST_SEL);
    assign commit     = data_phase && last_nib && !wr_n && wr_ok_q;

    // Collected nibbles plus the final nibble on the bus form the word to commit.
    always_comb begin
        commit_word         = '0;
        commit_word[NIBS-1] = wdata_nib;
        for (int i = 0; i < NIBS - 1; i++) begin
            commit_word[i] = shadow_q[i];
        end
    end

    always_comb begin
        addr_d  = addr_q;
        sel_d   = sel_q;
        wr_ok_d = wr_ok_q;
        if (addr_strobe) begin
            addr_d  = addr_in;
            sel_d   = '0;
            wr_ok_d = 1'b0;
        end else if (last_nib) begin
            sel_d   = '0;
            wr_ok_d = 1'b0;
`ifdef NIBSRAM_BURST_EN
            addr_d  = addr_q + ADDR_W'(1);
`endif
        end else begin
            sel_d = sel_q + SEL_W'(1);
            if (sel_q == '0) begin
                wr_ok_d = ~wr_n;
            end else begin
                wr_ok_d = wr_ok_q & ~wr_n;
            end
        end
    end

    // Read data tracks the upcoming address/nibble; a same-edge commit bypasses the stale RAM word.
    always_comb begin
        load_word = mem[addr_d];
        if (commit && (addr_q == addr_d)) begin
            load_word = commit_word;
        end
        rdata_d = load_word[sel_d];
    end

    for (genvar gi = 0; gi < NIBS - 1; gi++) begin : g_shadow
        logic cap;
        if (gi == 0) begin : g_first
            assign cap = data_phase && (sel_q == '0) && !wr_n;
        end else begin : g_mid
            assign cap = data_phase && (sel_q == SEL_W'(gi));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q[gi] <= '0;
            end else if (cap) begin
                shadow_q[gi] <= wdata_nib;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            sel_q   <= '0;
            wr_ok_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wr_ok_q <= wr_ok_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[addr_q] <= commit_word;
        end
    end

    assign rdata_nib = rdata_q;
    assign nib_sel   = sel_q;

endmodule

// File: tb/tb_nibble_sram_bridge.sv
// Scoreboard bench for nibble_sram_bridge at default geometry and at NIB_W=8, NIBS=3, ADDR_W=4.
`timescale 1ns/1ps
module tb_nibble_sram_bridge;

    localparam int AW  = 7;
    localparam int NW  = 4;
    localparam int NS  = 2;
    localparam int BAW = 4;
    localparam int BNW = 8;
    localparam int BNS = 3;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;

    logic           a_strobe = 1'b0;
    logic           a_wr_n   = 1'b1;
    logic [AW-1:0]  a_addr   = '0;
    logic [NW-1:0]  a_wdata  = '0;
    logic [NW-1:0]  a_rdata;
    logic [0:0]     a_sel;

    logic           b_strobe = 1'b0;
    logic           b_wr_n   = 1'b1;
    logic [BAW-1:0] b_addr   = '0;
    logic [BNW-1:0] b_wdata  = '0;
    logic [BNW-1:0] b_rdata;
    logic [1:0]     b_sel;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] val;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] a_model [128];

    always #5 clk = ~clk;

    nibble_sram_bridge #(.ADDR_W(AW), .NIB_W(NW), .NIBS(NS)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_strobe(a_strobe),
        .addr_in    (a_addr),
        .wr_n       (a_wr_n),
        .wdata_nib  (a_wdata),
        .rdata_nib  (a_rdata),
        .nib_sel    (a_sel)
    );

    nibble_sram_bridge #(.ADDR_W(BAW), .NIB_W(BNW), .NIBS(BNS)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_strobe(b_strobe),
        .addr_in    (b_addr),
        .wr_n       (b_wr_n),
        .wdata_nib  (b_wdata),
        .rdata_nib  (b_rdata),
        .nib_sel    (b_sel)
    );

    // One clock for DUT A; outputs are stable for sampling at the following negedge.
    task automatic a_cycle(input logic strobe, input logic [AW-1:0] addr,
                           input logic wr_n, input logic [NW-1:0] wd);
        a_strobe = strobe;
        a_addr   = addr;
        a_wr_n   = wr_n;
        a_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        a_strobe = 1'b0;
        a_wr_n   = 1'b1;
    endtask

    task automatic b_cycle(input logic strobe, input logic [BAW-1:0] addr,
                           input logic wr_n, input logic [BNW-1:0] wd);
        b_strobe = strobe;
        b_addr   = addr;
        b_wr_n   = wr_n;
        b_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        b_strobe = 1'b0;
        b_wr_n   = 1'b1;
    endtask

    task automatic a_write(input logic [AW-1:0] addr, input logic [7:0] word);
        a_cycle(1'b1, addr, 1'b1, '0);
        for (int i = 0; i < NS; i++) a_cycle(1'b0, '0, 1'b0, word[i*NW +: NW]);
        a_model[addr] = word;
        $display("a write addr=%h word=%h", addr, word);
    endtask

    task automatic b_write(input logic [BAW-1:0] addr, input logic [23:0] word);
        b_cycle(1'b1, addr, 1'b1, '0);
        for (int i = 0; i < BNS; i++) b_cycle(1'b0, '0, 1'b0, word[i*BNW +: BNW]);
        $display("b write addr=%h word=%h", addr, word);
    endtask

    // Expected nibbles of a strobe-then-read sequence on DUT A, from the model memory.
    task automatic a_push_read(input logic [AW-1:0] addr, input int n);
        logic [AW-1:0] wa;
        exp_t          x;
        for (int k = 0; k < n; k++) begin
`ifdef NIBSRAM_BURST_EN
            wa = addr + AW'(k / NS);
`else
            wa = addr;
`endif
            x.sel = 2'(k % NS);
            x.val = {4'b0, a_model[wa][x.sel*NW +: NW]};
            sb_q.push_back(x);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_sel !== 1'b0 || a_rdata !== 4'h0) begin
            failures++;
            $display("FAIL reset_a: got sel=%0d rdata=%h, want sel=0 rdata=0", a_sel, a_rdata);
        end
        checks++;
        if (b_sel !== 2'd0 || b_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_b: got sel=%0d rdata=%h, want sel=0 rdata=00", b_sel, b_rdata);
        end
        rst_n = 1'b1;
        $display("reset a_sel=%0d a_rdata=%h b_sel=%0d b_rdata=%h", a_sel, a_rdata, b_sel, b_rdata);
    endtask

    task automatic test_write_read();
        a_write(7'h12, 8'h5A);
        sb_q.push_back('{2'd0, 8'h0A});
        sb_q.push_back('{2'd1, 8'h05});
        for (int k = 0; k < 2; k++) begin
            if (k == 0) a_cycle(1'b1, 7'h12, 1'b1, '0);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL write_read[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("write_read[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
    endtask

    task automatic test_aborted_write();
        a_write(7'h20, 8'h33);
        a_cycle(1'b1, 7'h20, 1'b1, '0);
        a_cycle(1'b0, '0, 1'b0, 4'hF);
        a_push_read(7'h20, 2);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) a_cycle(1'b1, 7'h20, 1'b1, '0);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL aborted_write[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("aborted_write[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
    endtask

    task automatic test_poison();
        a_write(7'h21, 8'h77);
        a_cycle(1'b1, 7'h21, 1'b1, '0);
        a_cycle(1'b0, '0, 1'b1, 4'h1);
        a_cycle(1'b0, '0, 1'b0, 4'h2);
        a_push_read(7'h21, 2);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) a_cycle(1'b1, 7'h21, 1'b1, '0);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL poisoned[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("poisoned[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
        // Strobe arriving with wr_n=0 on the would-be commit nibble must not write.
        a_cycle(1'b1, 7'h21, 1'b1, '0);
        a_cycle(1'b0, '0, 1'b0, 4'h8);
        a_push_read(7'h21, 2);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) a_cycle(1'b1, 7'h21, 1'b0, 4'h9);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL strobe_wins[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("strobe_wins[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
    endtask

    task automatic test_bypass();
        a_write(7'h05, 8'h96);
        a_write(7'h06, 8'hE1);
        a_cycle(1'b1, 7'h05, 1'b1, '0);
        a_cycle(1'b0, '0, 1'b0, 4'h4);
`ifdef NIBSRAM_BURST_EN
        sb_q.push_back('{2'd0, 8'h01});
        sb_q.push_back('{2'd1, 8'h0E});
`else
        sb_q.push_back('{2'd0, 8'h04});
        sb_q.push_back('{2'd1, 8'h0C});
`endif
        for (int k = 0; k < 2; k++) begin
            if (k == 0) a_cycle(1'b0, '0, 1'b0, 4'hC);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL bypass[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("bypass[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
        a_model[7'h05] = 8'hC4;
        a_push_read(7'h05, 2);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) a_cycle(1'b1, 7'h05, 1'b1, '0);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL bypass_mem[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("bypass_mem[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
    endtask

    task automatic test_burst();
        a_write(7'h7F, 8'h21);
        a_write(7'h00, 8'h43);
        sb_q.push_back('{2'd0, 8'h01});
        sb_q.push_back('{2'd1, 8'h02});
`ifdef NIBSRAM_BURST_EN
        sb_q.push_back('{2'd0, 8'h03});
        sb_q.push_back('{2'd1, 8'h04});
`else
        sb_q.push_back('{2'd0, 8'h01});
        sb_q.push_back('{2'd1, 8'h02});
`endif
        for (int k = 0; k < 4; k++) begin
            if (k == 0) a_cycle(1'b1, 7'h7F, 1'b1, '0);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL burst[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("burst[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
    endtask

    task automatic test_reset_mid();
        a_write(7'h30, 8'h99);
        a_cycle(1'b1, 7'h30, 1'b1, '0);
        a_wr_n  = 1'b0;
        a_wdata = 4'h5;
        @(posedge clk);
        #2;
        checks++;
        if (a_sel !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: got sel=%0d, want sel=1", a_sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_sel !== 1'b0 || a_rdata !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid_async: got sel=%0d rdata=%h, want sel=0 rdata=0", a_sel, a_rdata);
        end
        $display("reset_mid_async sel=%0d rdata=%h", a_sel, a_rdata);
        a_wr_n  = 1'b1;
        a_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_push_read(7'h30, 2);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) a_cycle(1'b1, 7'h30, 1'b1, '0);
            else        a_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, a_sel} !== e.sel || {4'b0, a_rdata} !== e.val) begin
                failures++;
                $display("FAIL reset_mid_mem[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, a_sel, a_rdata, e.sel, e.val[3:0]);
            end
            $display("reset_mid_mem[%0d] sel=%0d rdata=%h", k, a_sel, a_rdata);
        end
    endtask

    task automatic test_wide_config();
        b_write(4'h3, 24'hABCDEF);
        b_write(4'h4, 24'h010203);
        sb_q.push_back('{2'd0, 8'hEF});
        sb_q.push_back('{2'd1, 8'hCD});
        sb_q.push_back('{2'd2, 8'hAB});
`ifdef NIBSRAM_BURST_EN
        sb_q.push_back('{2'd0, 8'h03});
`else
        sb_q.push_back('{2'd0, 8'hEF});
`endif
        for (int k = 0; k < 4; k++) begin
            if (k == 0) b_cycle(1'b1, 4'h3, 1'b1, '0);
            else        b_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if (b_sel !== e.sel || b_rdata !== e.val) begin
                failures++;
                $display("FAIL wide_read[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, b_sel, b_rdata, e.sel, e.val);
            end
            $display("wide_read[%0d] sel=%0d rdata=%h", k, b_sel, b_rdata);
        end
    endtask

    task automatic test_reset_mid_wide();
        b_cycle(1'b1, 4'h3, 1'b1, '0);
        b_cycle(1'b0, '0, 1'b0, 8'h11);
        b_wr_n  = 1'b0;
        b_wdata = 8'h22;
        @(posedge clk);
        #2;
        checks++;
        if (b_sel !== 2'd2) begin
            failures++;
            $display("FAIL wide_reset_pre: got sel=%0d, want sel=2", b_sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_sel !== 2'd0 || b_rdata !== 8'h00) begin
            failures++;
            $display("FAIL wide_reset_async: got sel=%0d rdata=%h, want sel=0 rdata=00", b_sel, b_rdata);
        end
        $display("wide_reset_async sel=%0d rdata=%h", b_sel, b_rdata);
        b_wr_n  = 1'b1;
        b_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{2'd0, 8'hEF});
        sb_q.push_back('{2'd1, 8'hCD});
        sb_q.push_back('{2'd2, 8'hAB});
        for (int k = 0; k < 3; k++) begin
            if (k == 0) b_cycle(1'b1, 4'h3, 1'b1, '0);
            else        b_cycle(1'b0, '0, 1'b1, '0);
            e = sb_q.pop_front();
            checks++;
            if (b_sel !== e.sel || b_rdata !== e.val) begin
                failures++;
                $display("FAIL wide_reset_mem[%0d]: got sel=%0d rdata=%h, want sel=%0d rdata=%h",
                         k, b_sel, b_rdata, e.sel, e.val);
            end
            $display("wide_reset_mem[%0d] sel=%0d rdata=%h", k, b_sel, b_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_aborted_write();
        test_poison();
        test_bypass();
        test_burst();
        test_reset_mid();
        test_wide_config();
        test_reset_mid_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/nibble_sram_bridge.md
Name: nibble_sram_bridge

Overview:
Parametrised nibble-serial memory device for the moonbase CPU pin bus. It generalises the 7-bit-address, 2-nibble external SRAM to configurable address width, nibble width and nibbles-per-word. It adds registered read data with write bypass, all-or-nothing word commits, and an optional auto-incrementing burst mode. It sits between the CPU io pins and an internal flop-array RAM, or stands alone as an on-chip memory model.

Parameters:
ADDR_W, 7, word address width; depth = 2**ADDR_W words
NIB_W, 4, bits per bus nibble
NIBS, 2, nibbles per word (>=2); word width = NIB_W*NIBS

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous, active-low
addr_strobe  in  1  high = address phase; addr_in is captured
addr_in  in  ADDR_W  word address, valid when addr_strobe is high
wr_n  in  1  active-low write enable for the data phase
wdata_nib  in  NIB_W  write nibble for the current nib_sel
rdata_nib  out  NIB_W  read nibble for the current nib_sel, registered
nib_sel  out  $clog2(NIBS)  current nibble index; nibble 0 is least significant

Behaviour:
- Reset (rst_n low, asynchronous):
  - addr_q=0, nib_sel=0, shadow=0, wr_ok=0, rdata_nib=0.
  - RAM contents are not reset.
  - Reset mid-word discards any partial write.
- Address phase (addr_strobe=1 at an edge):
  - addr_q<=addr_in, nib_sel<=0, wr_ok<=0.
  - wr_n and wdata_nib are ignored. Strobe wins over a simultaneous write, so no RAM update occurs.
- Data phase (addr_strobe=0 at an edge):
  - nib_sel<=(nib_sel==NIBS-1)?0:nib_sel+1.
  - Wrap without NIBSRAM_BURST_EN: addr_q holds, and the next word access re-uses the same address.
- Write collection:
  - At nib_sel=0 with wr_n=0: shadow[0]<=wdata_nib, wr_ok<=1.
  - At 0<nib_sel<NIBS-1: shadow[nib_sel]<=wdata_nib, wr_ok<=wr_ok&~wr_n.
  - A nibble with wr_n=1 poisons the word.
- Commit:
  - At nib_sel=NIBS-1, if wr_n=0 and wr_ok=1, mem[addr_q]<={wdata_nib, shadow[NIBS-2:0]} on that edge.
  - Otherwise no write. wr_ok clears after the last nibble.
  - Partial words are never written.
- Read data:
  - rdata_nib is registered. Each edge it loads nibble nib_sel_next of word mem[addr_q_next], so it always matches the nib_sel being presented.
  - Read latency is zero cycles relative to nib_sel, one cycle relative to addr_strobe.
- Bypass: if a commit and the rdata load address coincide on the same edge, rdata_nib takes the nibble from the newly committed word, not the stale RAM value.
- Nibble order: LS nibble first, for both reads and writes.
- Address arithmetic: unsigned, modulo 2**ADDR_W.
- Non-power-of-two NIBS: nib_sel counts only 0..NIBS-1.

Optional Feature:
NIBSRAM_BURST_EN
- Defined: on the data-phase edge where nib_sel wraps NIBS-1->0, addr_q<=addr_q+1 (0x7F wraps to 0x00 at default width). This applies after any commit to the old addr_q. rdata_nib pre-loads nibble 0 of the incremented address on that edge. Enables streaming reads and writes without re-strobing.
- Undefined: addr_q changes only on addr_strobe.

Test Plan:
1. Write/read at defaults:
   - Stimulus: strobe addr 0x12; two cycles wr_n=0 with nibbles 0xA then 0x5; strobe 0x12; two read cycles.
   - Response: mem[0x12]=0x5A; rdata_nib=0xA then 0x5; nib_sel=0,1.
2. Aborted write:
   - Stimulus: mem[0x20]=0x33; strobe 0x20; one nibble 0xF with wr_n=0; strobe 0x20 again.
   - Response: mem[0x20] stays 0x33; the read returns 0x3, 0x3.
3. Poisoned and simultaneous writes:
   - Stimulus A: write to 0x21 with wr_n=1 on nibble 0 and wr_n=0 on nibble 1.
   - Stimulus B: assert strobe and wr_n=0 in the same cycle.
   - Response: no RAM change in either case.
4. Bypass:
   - Stimulus: burst off; write 0xC4 to 0x05; keep addr_strobe=0.
   - Response: the cycle after commit, nib_sel=0 and rdata_nib=0x4 (new data); the next cycle gives 0xC.
5. Burst:
   - Stimulus: mem[0x7F]=0x21, mem[0x00]=0x43; strobe 0x7F; four data cycles.
   - Response with NIBSRAM_BURST_EN: rdata 1,2,3,4.
   - Response without it: 1,2,1,2.
6. Reset mid-operation:
   - Stimulus: rst_n low asynchronously between nibble 0 and nibble 1 of a write to 0x30 (old 0x99).
   - Response: immediately nib_sel=0 and rdata_nib=0; mem[0x30] stays 0x99.
   - Config: also run with NIB_W=8, NIBS=3, ADDR_W=4, writing 0xABCDEF.
